cpu_ctrl_seq: RTL and testbench

//   Control sequencer that sits directly downstream of the 2-bit step counter.

---
 rtl/cpu_ctrl_seq.sv | 131 +++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer fed by the 2-bit step counter: holds the instruction
// register, decodes opcode x T-state into datapath strobes, tracks RUN/HALT
// and flags any T-state sequence that does not advance by one (mod 4).
module cpu_ctrl_seq #(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [1:0]               state,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic                     acc_zero,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic                     mar_load,
  output logic                     mar_sel_pc,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic                     ir_load,
  output logic                     pc_inc,
  output logic                     pc_load,
  output logic                     acc_load,
  output logic [1:0]               alu_op,
  output logic                     halted,
  output logic                     seq_err
);

  localparam int ADDR_W = INSTR_W - OPC_W;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

  typedef enum logic {
    RUN,
    HALT
  } run_t;

  run_t               run_state;
  logic [INSTR_W-1:0] ir;
  logic [1:0]         prev_state;
  logic [1:0]         next_expected;
  logic               prev_valid;
  logic [OPC_W-1:0]   opcode;

  assign opcode        = ir[INSTR_W-1 -: OPC_W];
  assign operand       = ir[ADDR_W-1:0];
  assign halted        = (run_state == HALT);
  assign next_expected = prev_state + 2'd1;

  // IR capture, RUN/HALT state and sticky T-state sequence check
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      run_state  <= RUN;
      ir         <= '0;
      prev_state <= '0;
      prev_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      prev_state <= state;
      prev_valid <= 1'b1;
      if (prev_valid && (state != next_expected))
        seq_err <= 1'b1;
      if (run_state == RUN) begin
        if (state == 2'd1)
          ir <= instr_in;
        if ((state == 2'd2) && (opcode == OP_HLT))
          run_state <= HALT;
      end
    end
  end

  // Zero-latency strobe decode of T-state x opcode; silenced in HALT and clear
  always_comb begin
    mar_load   = 1'b0;
    mar_sel_pc = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_load   = 1'b0;
    alu_op     = 2'b00;
    if (!clear && (run_state == RUN)) begin
      case (state)
        2'd0: begin
          mar_load   = 1'b1;
          mar_sel_pc = 1'b1;
        end
        2'd1: begin
          mem_rd  = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
        2'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_load = 1'b1;
            OP_JMP:                         pc_load  = 1'b1;
            OP_JZ:                          pc_load  = acc_zero;
            default:                        ;
          endcase
        end
        2'd3: begin
          case (opcode)
            OP_LDA: begin
              mem_rd   = 1'b1;
              acc_load = 1'b1;
              alu_op   = 2'b00;
            end
            OP_ADD: begin
              mem_rd   = 1'b1;
              acc_load = 1'b1;
              alu_op   = 2'b01;
            end
            OP_SUB: begin
              mem_rd   = 1'b1;
              acc_load = 1'b1;
              alu_op   = 2'b10;
            end
            OP_STA:  mem_wr = 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: directed T-state/instruction vectors with
// hand-computed expected strobes, checked by an independent monitor process.
module tb_cpu_ctrl_seq;

  logic       clock;
  logic       clear;
  logic [1:0] state;
  logic [7:0] instr_in;
  logic       acc_zero;
  logic [3:0] operand;
  logic       mar_load, mar_sel_pc, mem_rd, mem_wr, ir_load;
  logic       pc_inc, pc_load, acc_load, halted, seq_err;
  logic [1:0] alu_op;

  cpu_ctrl_seq #(.INSTR_W(8), .OPC_W(4)) dut (
    .clock      (clock),
    .clear      (clear),
    .state      (state),
    .instr_in   (instr_in),
    .acc_zero   (acc_zero),
    .operand    (operand),
    .mar_load   (mar_load),
    .mar_sel_pc (mar_sel_pc),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .acc_load   (acc_load),
    .alu_op     (alu_op),
    .halted     (halted),
    .seq_err    (seq_err)
  );

  // Strobe patterns, bit order:
  // {mar_load, mar_sel_pc, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, alu_op[1:0]}
  localparam logic [9:0] S_NONE = 10'b00_0000_0000;
  localparam logic [9:0] S_T0   = 10'b11_0000_0000;
  localparam logic [9:0] S_T1   = 10'b00_1011_0000;
  localparam logic [9:0] S_T2M  = 10'b10_0000_0000;
  localparam logic [9:0] S_PCL  = 10'b00_0000_1000;
  localparam logic [9:0] S_LDA3 = 10'b00_1000_0100;
  localparam logic [9:0] S_ADD3 = 10'b00_1000_0101;
  localparam logic [9:0] S_SUB3 = 10'b00_1000_0110;
  localparam logic [9:0] S_STA3 = 10'b00_0100_0000;

  typedef struct {
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Clock: posedges at 10, 20, ...; negedges at 5, 15, ...
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs, queue its expectation, advance past the next edge
  task automatic step(input logic [1:0] st, input logic [7:0] ins, input logic az,
                      input logic clr, input logic [9:0] s, input logic h,
                      input logic e, input logic [3:0] op, input string nm);
    exp_t x;
    clear    = clr;
    state    = st;
    instr_in = ins;
    acc_zero = az;
    x.v  = {s, h, e, op};
    x.nm = nm;
    exp_q.push_back(x);
    @(posedge clock);
    #1;
  endtask

  // Monitor: samples mid-low-phase, pops and compares one expectation per cycle
  initial begin
    exp_t x;
    logic [15:0] act;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        act = {mar_load, mar_sel_pc, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
               acc_load, alu_op, halted, seq_err, operand};
        checks++;
        if (act !== x.v) begin
          errors++;
          $display("FAIL %s: got %b required %b (strobes|halted|seq_err|operand)",
                   x.nm, act, x.v);
        end
      end
    end
  end

  // Global time bound
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t x;
    // 1) reset: strobes gated even though state=T1 is presented
    clear    = 1'b1;
    state    = 2'd1;
    instr_in = 8'h00;
    acc_zero = 1'b0;
    x.v  = {S_NONE, 1'b0, 1'b0, 4'h0};
    x.nm = "reset";
    exp_q.push_back(x);
    #15;
    // release at t=15 with state T0
    step(2'd0, 8'h00, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h0, "nop_t0");
    step(2'd1, 8'h00, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h0, "nop_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h0, "nop_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h0, "nop_t3");
    // 2) LDA 1A
    step(2'd0, 8'h1A, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h0, "lda_t0");
    step(2'd1, 8'h1A, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h0, "lda_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_T2M,  1'b0, 1'b0, 4'hA, "lda_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_LDA3, 1'b0, 1'b0, 4'hA, "lda_t3");
    // 3) ADD 23, SUB 34, STA 45
    step(2'd0, 8'h23, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'hA, "add_t0");
    step(2'd1, 8'h23, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'hA, "add_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_T2M,  1'b0, 1'b0, 4'h3, "add_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_ADD3, 1'b0, 1'b0, 4'h3, "add_t3");
    step(2'd0, 8'h34, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h3, "sub_t0");
    step(2'd1, 8'h34, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h3, "sub_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_T2M,  1'b0, 1'b0, 4'h4, "sub_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_SUB3, 1'b0, 1'b0, 4'h4, "sub_t3");
    step(2'd0, 8'h45, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h4, "sta_t0");
    step(2'd1, 8'h45, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h4, "sta_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_T2M,  1'b0, 1'b0, 4'h5, "sta_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_STA3, 1'b0, 1'b0, 4'h5, "sta_t3");
    // 4) JZ not taken, JZ taken, JMP
    step(2'd0, 8'h67, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h5, "jz0_t0");
    step(2'd1, 8'h67, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h5, "jz0_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h7, "jz0_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h7, "jz0_t3");
    step(2'd0, 8'h67, 1'b1, 1'b0, S_T0,   1'b0, 1'b0, 4'h7, "jz1_t0");
    step(2'd1, 8'h67, 1'b1, 1'b0, S_T1,   1'b0, 1'b0, 4'h7, "jz1_t1");
    step(2'd2, 8'h00, 1'b1, 1'b0, S_PCL,  1'b0, 1'b0, 4'h7, "jz1_t2");
    step(2'd3, 8'h00, 1'b1, 1'b0, S_NONE, 1'b0, 1'b0, 4'h7, "jz1_t3");
    step(2'd0, 8'h5C, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h7, "jmp_t0");
    step(2'd1, 8'h5C, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h7, "jmp_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_PCL,  1'b0, 1'b0, 4'hC, "jmp_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'hC, "jmp_t3");
    // 5) HLT, then a full frozen instruction period, then clear
    step(2'd0, 8'hF0, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'hC, "hlt_t0");
    step(2'd1, 8'hF0, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'hC, "hlt_t1");
    step(2'd2, 8'h1B, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h0, "hlt_t2");
    step(2'd3, 8'h1B, 1'b0, 1'b0, S_NONE, 1'b1, 1'b0, 4'h0, "hlt_t3");
    step(2'd0, 8'h1B, 1'b0, 1'b0, S_NONE, 1'b1, 1'b0, 4'h0, "halt_t0");
    step(2'd1, 8'h1B, 1'b0, 1'b0, S_NONE, 1'b1, 1'b0, 4'h0, "halt_t1");
    step(2'd2, 8'h1B, 1'b1, 1'b0, S_NONE, 1'b1, 1'b0, 4'h0, "halt_t2");
    step(2'd3, 8'h1B, 1'b0, 1'b0, S_NONE, 1'b1, 1'b0, 4'h0, "halt_t3");
    step(2'd0, 8'h1B, 1'b0, 1'b1, S_NONE, 1'b0, 1'b0, 4'h0, "halt_clear");
    // 6) sequence error 0,1,3 then sticky, clear at T2, clean restart
    step(2'd0, 8'h00, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h0, "seq_t0");
    step(2'd1, 8'h00, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h0, "seq_t1");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h0, "seq_skip");
    step(2'd0, 8'h00, 1'b0, 1'b0, S_T0,   1'b0, 1'b1, 4'h0, "seq_err_set");
    step(2'd1, 8'h00, 1'b0, 1'b0, S_T1,   1'b0, 1'b1, 4'h0, "seq_err_sticky");
    step(2'd2, 8'h00, 1'b0, 1'b1, S_NONE, 1'b0, 1'b0, 4'h0, "seq_clear_t2");
    step(2'd0, 8'h00, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h0, "restart_t0");
    step(2'd1, 8'h00, 1'b0, 1'b0, S_T1,   1'b0, 1'b0, 4'h0, "restart_t1");
    step(2'd2, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h0, "restart_t2");
    step(2'd3, 8'h00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 4'h0, "restart_t3");
    step(2'd0, 8'h00, 1'b0, 1'b0, S_T0,   1'b0, 1'b0, 4'h0, "wrap_t0");

    // Drain, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(posedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count: got %0d required at least 12", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
